// File: rtl/riscv_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the memory port (slave).
// Request/grant handshake with a separate response strobe.
interface riscv_lsu_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            o_bus_req;
    logic            o_bus_we;
    logic [XLEN-1:0] o_bus_addr;
    logic [XLEN-1:0] o_bus_wdata;
    logic [3:0]      o_bus_be;
    logic            i_bus_gnt;
    logic            i_bus_rvalid;
    logic [XLEN-1:0] i_bus_rdata;

    modport master (
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        input  i_bus_gnt, i_bus_rvalid, i_bus_rdata
    );

    modport slave (
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        output i_bus_gnt, i_bus_rvalid, i_bus_rdata
    );
endinterface

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit: turns M-stage accesses into bus transactions,
// stalls the pipeline while one is outstanding and returns extended load data.
module riscv_lsu #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_mem_en,
    input  logic             i_mem_we,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_addr,
    input  logic [XLEN-1:0]  i_wdata,
    output logic [XLEN-1:0]  o_read_data_m,
    output logic             o_stall,
    output logic             o_misaligned,
    output logic             o_bus_err,
    riscv_lsu_if.master      bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e            state_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [XLEN-1:0]   bus_addr_q;
    logic [XLEN-1:0]   bus_wdata_q;
    logic [3:0]        bus_be_q;
    logic [XLEN-1:0]   read_data_q;
    logic              bus_err_q;
    logic              bad_c;
    logic              start_c;

    function automatic logic [XLEN-1:0] fmt_wdata(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] fmt_be(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (!we) return 4'b1111;
        case (f3[1:0])
            2'b00:   return 4'(4'b0001 << off);
            2'b01:   return 4'(4'b0011 << off);
            default: return 4'b1111;
        endcase
    endfunction

    // Lane select by the latched byte offset, then sign/zero extension.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] rd);
        logic [XLEN-1:0] sh;
        sh = rd >> {off, 3'b000};
        case (f3)
            3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        bad_c = 1'b0;
        case (i_funct3)
            3'b000, 3'b100: bad_c = 1'b0;
            3'b001, 3'b101: bad_c = i_addr[0];
            3'b010:         bad_c = (i_addr[1:0] != 2'b00);
            default:        bad_c = 1'b1;
        endcase
    end

    assign o_misaligned = i_mem_en & bad_c;
    assign start_c      = i_mem_en & ~bad_c;
    assign o_stall      = ((state_q == IDLE) & start_c) | (state_q == REQ) | (state_q == WAIT);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= 4'b0000;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bus_err_q <= 1'b0;
                    if (start_c) begin
                        we_q        <= i_mem_we;
                        funct3_q    <= i_funct3;
                        off_q       <= i_addr[1:0];
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= i_mem_we;
                        bus_addr_q  <= {i_addr[XLEN-1:2], 2'b00};
                        bus_wdata_q <= fmt_wdata(i_funct3, i_wdata);
                        bus_be_q    <= fmt_be(i_mem_we, i_funct3, i_addr[1:0]);
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    // rvalid alongside gnt is ignored; the bus never responds that early
                    if (bus.i_bus_gnt) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.i_bus_rvalid) begin
                        read_data_q <= we_q ? '0 : extend(funct3_q, off_q, bus.i_bus_rdata);
                        state_q     <= DONE;
                    end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYC)) begin
                        read_data_q <= '0;
                        bus_err_q   <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    bus_err_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_read_data_m   = read_data_q;
    assign o_bus_err       = bus_err_q;
    assign bus.o_bus_req   = bus_req_q;
    assign bus.o_bus_we    = bus_we_q;
    assign bus.o_bus_addr  = bus_addr_q;
    assign bus.o_bus_wdata = bus_wdata_q;
    assign bus.o_bus_be    = bus_be_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: the driver queues expected bus requests and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_riscv_lsu;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] read_data;
    logic        stall, misaligned, bus_err;

    int checks = 0;
    int errors = 0;

    riscv_lsu_if bus_if ();

    riscv_lsu #(.XLEN(32), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_mem_en(mem_en), .i_mem_we(mem_we),
        .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
        .o_read_data_m(read_data), .o_stall(stall), .o_misaligned(misaligned),
        .o_bus_err(bus_err), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_wd;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stall_cyc;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: bus request fields while req is high, completion when stall drops.
    logic prev_stall = 1'b0;
    int   stall_cnt = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
            stall_cnt  = 0;
        end else begin
            if (bus_if.o_bus_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'(bus_if.o_bus_req), 32'd0);
                end else begin
                    chk("req_we", 32'(bus_if.o_bus_we), 32'(req_q[0].we));
                    chk("req_addr", bus_if.o_bus_addr, req_q[0].addr);
                    chk("req_be", 32'(bus_if.o_bus_be), 32'(req_q[0].be));
                    if (req_q[0].chk_wd) chk("req_wdata", bus_if.o_bus_wdata, req_q[0].wdata);
                    if (bus_if.i_bus_gnt) void'(req_q.pop_front());
                end
            end
            if (stall) stall_cnt++;
            if (prev_stall && !stall) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("read_data", read_data, r.rd);
                    chk("bus_err", 32'(bus_err), 32'(r.err));
                    chk("stall_cycles", 32'(stall_cnt), 32'(r.stall_cyc));
                end
                stall_cnt = 0;
            end else begin
                chk("bus_err_idle", 32'(bus_err), 32'd0);
            end
            prev_stall = stall;
        end
    end

    // One access; rv_dly < 0 means rvalid never arrives.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata, input req_t exp_req, input rsp_t exp_rsp);
        req_q.push_back(exp_req);
        rsp_q.push_back(exp_rsp);
        @(posedge clk) #1;
        mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk) #1;
        repeat (gnt_dly) @(posedge clk) #1;
        bus_if.i_bus_gnt = 1'b1;
        @(posedge clk) #1;
        bus_if.i_bus_gnt = 1'b0;
        if (rv_dly >= 0) begin
            repeat (rv_dly) @(posedge clk) #1;
            bus_if.i_bus_rvalid = 1'b1;
            bus_if.i_bus_rdata  = rdata;
            @(posedge clk) #1;
            bus_if.i_bus_rvalid = 1'b0;
        end else begin
            int n = 0;
            while (stall && n < 20) begin
                @(posedge clk) #1;
                n++;
            end
            if (stall) chk("timeout_bound", 32'(stall), 32'd0);
        end
        @(posedge clk) #1;
        mem_en = 1'b0;
    endtask

    function automatic req_t mk_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                                    input logic [31:0] wd, input bit cw);
        req_t r;
        r.we = we; r.addr = a; r.be = be; r.wdata = wd; r.chk_wd = cw;
        return r;
    endfunction

    function automatic rsp_t mk_rsp(input logic [31:0] rd, input logic err, input int sc);
        rsp_t r;
        r.rd = rd; r.err = err; r.stall_cyc = sc;
        return r;
    endfunction

    initial begin
        bus_if.i_bus_gnt = 1'b0;
        bus_if.i_bus_rvalid = 1'b0;
        bus_if.i_bus_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus_if.o_bus_req), 32'd0);
        chk("rst_be", 32'(bus_if.o_bus_be), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk) #1;
        rstn = 1'b1;

        access(1'b0, 3'b010, 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF,
               mk_req(1'b0, 32'h1000, 4'b1111, 32'h0, 1'b0), mk_rsp(32'hDEADBEEF, 1'b0, 3));
        access(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF0000,
               mk_req(1'b0, 32'h1000, 4'b1111, 32'h0, 1'b0), mk_rsp(32'hFFFFFF80, 1'b0, 3));
        access(1'b0, 3'b100, 32'h1003, 32'h0, 0, 0, 32'h80FF0000,
               mk_req(1'b0, 32'h1000, 4'b1111, 32'h0, 1'b0), mk_rsp(32'h00000080, 1'b0, 3));
        access(1'b0, 3'b001, 32'h1002, 32'h0, 0, 0, 32'h80010000,
               mk_req(1'b0, 32'h1000, 4'b1111, 32'h0, 1'b0), mk_rsp(32'hFFFF8001, 1'b0, 3));
        access(1'b0, 3'b101, 32'h1002, 32'h0, 0, 0, 32'h80010000,
               mk_req(1'b0, 32'h1000, 4'b1111, 32'h0, 1'b0), mk_rsp(32'h00008001, 1'b0, 3));
        access(1'b1, 3'b000, 32'h2002, 32'h000000A5, 0, 0, 32'h55555555,
               mk_req(1'b1, 32'h2000, 4'b0100, 32'hA5A5A5A5, 1'b1), mk_rsp(32'h0, 1'b0, 3));
        access(1'b1, 3'b001, 32'h2002, 32'h00001234, 0, 0, 32'h55555555,
               mk_req(1'b1, 32'h2000, 4'b1100, 32'h12341234, 1'b1), mk_rsp(32'h0, 1'b0, 3));
        access(1'b1, 3'b010, 32'h2004, 32'hCAFEF00D, 0, 0, 32'h0,
               mk_req(1'b1, 32'h2004, 4'b1111, 32'hCAFEF00D, 1'b1), mk_rsp(32'h0, 1'b0, 3));

        // Rejected accesses: no bus activity, no stall.
        @(posedge clk) #1;
        mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'b001; addr = 32'h3001;
        #1;
        chk("mis_lh", 32'(misaligned), 32'd1);
        chk("mis_lh_stall", 32'(stall), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        funct3 = 3'b011;
        #1;
        chk("mis_f011", 32'(misaligned), 32'd1);
        chk("mis_f011_stall", 32'(stall), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        mem_en = 1'b0;
        #1;
        chk("mis_clear", 32'(misaligned), 32'd0);

        access(1'b0, 3'b010, 32'h4000, 32'h0, 5, 3, 32'h12345678,
               mk_req(1'b0, 32'h4000, 4'b1111, 32'h0, 1'b0), mk_rsp(32'h12345678, 1'b0, 11));
        access(1'b0, 3'b010, 32'h5000, 32'h0, 0, -1, 32'h0,
               mk_req(1'b0, 32'h5000, 4'b1111, 32'h0, 1'b0), mk_rsp(32'h0, 1'b1, 2 + TO));
        access(1'b0, 3'b010, 32'h5004, 32'h0, 0, 0, 32'h0BADF00D,
               mk_req(1'b0, 32'h5004, 4'b1111, 32'h0, 1'b0), mk_rsp(32'h0BADF00D, 1'b0, 3));

        // Reset while WAIT: outputs clear asynchronously, late rvalid ignored.
        req_q.push_back(mk_req(1'b0, 32'h7000, 4'b1111, 32'h0, 1'b0));
        @(posedge clk) #1;
        mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h7000;
        @(posedge clk) #1;
        bus_if.i_bus_gnt = 1'b1;
        @(posedge clk) #1;
        bus_if.i_bus_gnt = 1'b0;
        @(posedge clk) #1;
        rstn = 1'b0;
        mem_en = 1'b0;
        #1;
        chk("arst_req", 32'(bus_if.o_bus_req), 32'd0);
        chk("arst_we", 32'(bus_if.o_bus_we), 32'd0);
        chk("arst_be", 32'(bus_if.o_bus_be), 32'd0);
        chk("arst_addr", bus_if.o_bus_addr, 32'd0);
        chk("arst_wdata", bus_if.o_bus_wdata, 32'd0);
        chk("arst_rdata", read_data, 32'd0);
        chk("arst_err", 32'(bus_err), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        @(posedge clk) #1;
        rstn = 1'b1;
        bus_if.i_bus_rvalid = 1'b1;
        bus_if.i_bus_rdata  = 32'hFFFFFFFF;
        @(posedge clk) #1;
        bus_if.i_bus_rvalid = 1'b0;
        @(posedge clk) #1;
        chk("late_rvalid_rdata", read_data, 32'd0);
        chk("late_rvalid_stall", 32'(stall), 32'd0);

        access(1'b0, 3'b010, 32'h6000, 32'h0, 0, 0, 32'hA5A55A5A,
               mk_req(1'b0, 32'h6000, 4'b1111, 32'h0, 1'b0), mk_rsp(32'hA5A55A5A, 1'b0, 3));

        repeat (3) @(posedge clk);
        #1;
        chk("req_queue_empty", 32'(req_q.size()), 32'd0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
